// File: rtl/exmem_if.sv
// exmem_if: valid/ready handshake carrying a control payload and a data payload
interface exmem_if #(
    parameter int CTRL_W = 6,
    parameter int DATA_W = 64+64+64+3+5
);
    logic              valid;
    logic              ready;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
    modport master (output valid, ctrl, data, input ready);
    modport slave  (input valid, ctrl, data, output ready);
endinterface

// File: rtl/exmem_stage.sv
// exmem_stage: EX/MEM pipeline register with optional skid entry and flush; EXMEM_STAGE_PERF_EN adds stall/flush counters
module exmem_stage #(
    parameter int DATA_W = 64+64+64+3+5,
    parameter int CTRL_W = 6,
    parameter int SKID   = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    exmem_if.slave     in_if,
    exmem_if.master    out_if,
    output logic [1:0] occupancy
`ifdef EXMEM_STAGE_PERF_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);
    logic              m_valid, s_valid, m_valid_n, s_valid_n;
    logic [CTRL_W-1:0] m_ctrl, s_ctrl, m_ctrl_n, s_ctrl_n;
    logic [DATA_W-1:0] m_data, s_data, m_data_n, s_data_n;
    logic              accept, consume;

    // With a skid entry, in_ready is purely registered so out_ready never reaches upstream
    assign in_if.ready  = (SKID != 0) ? !s_valid : (!m_valid || out_if.ready);
    assign accept       = in_if.valid && in_if.ready;
    assign consume      = m_valid && out_if.ready;
    assign out_if.valid = m_valid;
    assign out_if.ctrl  = m_ctrl;
    assign out_if.data  = m_data;
    assign occupancy    = {1'b0, m_valid} + {1'b0, s_valid};

    always_comb begin
        m_valid_n = m_valid;
        m_ctrl_n  = m_ctrl;
        m_data_n  = m_data;
        s_valid_n = s_valid;
        s_ctrl_n  = s_ctrl;
        s_data_n  = s_data;
        if (consume && s_valid) begin
            m_valid_n             = 1'b1;
            m_ctrl_n              = s_ctrl;
            m_data_n              = s_data;
            {s_valid_n, s_ctrl_n} = accept ? {1'b1, in_if.ctrl} : '0;
            s_data_n              = accept ? in_if.data : s_data;
        end else if (consume || !m_valid) begin
            m_valid_n = accept;
            m_ctrl_n  = accept ? in_if.ctrl : '0;
            m_data_n  = accept ? in_if.data : m_data;
        end else if (accept && SKID != 0) begin
            s_valid_n = 1'b1;
            s_ctrl_n  = in_if.ctrl;
            s_data_n  = in_if.data;
        end
        if (flush) begin
            m_valid_n = 1'b0;
            s_valid_n = 1'b0;
            m_ctrl_n  = '0;
            s_ctrl_n  = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
            m_ctrl  <= '0;
            s_ctrl  <= '0;
            m_data  <= '0;
            s_data  <= '0;
        end else begin
            m_valid <= m_valid_n;
            s_valid <= s_valid_n;
            m_ctrl  <= m_ctrl_n;
            s_ctrl  <= s_ctrl_n;
            m_data  <= m_data_n;
            s_data  <= s_data_n;
        end
    end

`ifdef EXMEM_STAGE_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (m_valid && !out_if.ready && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
            if (flush && occupancy != 2'd0 && flush_cnt != '1) flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_exmem_stage.sv
// tb_exmem_stage: scoreboard bench for exmem_stage with and without skid entry
module tb_exmem_stage;
    localparam int CW = 6;
    localparam int DW = 64+64+64+3+5;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic flush_a = 1'b0;
    logic flush_b = 1'b0;
    logic [1:0] occ_a, occ_b;
    int checks = 0;
    int passes = 0;
    logic [CW+DW-1:0] qa[$];
    logic [CW+DW-1:0] qb[$];
    exmem_if #(.CTRL_W(CW), .DATA_W(DW)) ia(), oa(), ib(), ob();
`ifdef EXMEM_STAGE_PERF_EN
    logic [31:0] stall_a, fcnt_a, stall_b, fcnt_b;
`endif

    exmem_stage #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) dut_a (
        .clk(clk), .reset(reset), .flush(flush_a), .in_if(ia), .out_if(oa), .occupancy(occ_a)
`ifdef EXMEM_STAGE_PERF_EN
        , .stall_cnt(stall_a), .flush_cnt(fcnt_a)
`endif
    );
    exmem_stage #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) dut_b (
        .clk(clk), .reset(reset), .flush(flush_b), .in_if(ib), .out_if(ob), .occupancy(occ_b)
`ifdef EXMEM_STAGE_PERF_EN
        , .stall_cnt(stall_b), .flush_cnt(fcnt_b)
`endif
    );

    always #5 clk = ~clk;

    // Scoreboards: at the falling edge, what is visible now is what the next rising edge will do
    always @(negedge clk) begin
        if (reset) qa.delete();
        else begin
            checks++;
            if (!oa.valid && oa.ctrl !== '0) $display("FAIL bubble_a ctrl got %h exp 0", oa.ctrl); else passes++;
            if (oa.valid && oa.ready) begin
                checks++;
                if (qa.size() == 0) $display("FAIL sb_a got %h exp nothing", {oa.ctrl, oa.data});
                else if ({oa.ctrl, oa.data} !== qa[0]) $display("FAIL sb_a got %h exp %h", {oa.ctrl, oa.data}, qa[0]);
                else passes++;
                if (qa.size() != 0) void'(qa.pop_front());
            end
            if (ia.valid && ia.ready) qa.push_back({ia.ctrl, ia.data});
            if (flush_a) qa.delete();
        end
    end

    always @(negedge clk) begin
        if (reset) qb.delete();
        else begin
            checks++;
            if (!ob.valid && ob.ctrl !== '0) $display("FAIL bubble_b ctrl got %h exp 0", ob.ctrl); else passes++;
            if (ob.valid && ob.ready) begin
                checks++;
                if (qb.size() == 0) $display("FAIL sb_b got %h exp nothing", {ob.ctrl, ob.data});
                else if ({ob.ctrl, ob.data} !== qb[0]) $display("FAIL sb_b got %h exp %h", {ob.ctrl, ob.data}, qb[0]);
                else passes++;
                if (qb.size() != 0) void'(qb.pop_front());
            end
            if (ib.valid && ib.ready) qb.push_back({ib.ctrl, ib.data});
            if (flush_b) qb.delete();
        end
    end

    function automatic logic [DW-1:0] rnd();
        logic [223:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return t[DW-1:0];
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        ia.valid = 0; ia.ctrl = 0; ia.data = 0; oa.ready = 0;
        ib.valid = 0; ib.ctrl = 0; ib.data = 0; ob.ready = 0;
        reset = 1;
        step; step;
        checks++; if (oa.valid !== 1'b0) $display("FAIL rst_valid got %0d exp 0", oa.valid); else passes++;
        checks++; if (oa.ctrl !== '0) $display("FAIL rst_ctrl got %h exp 0", oa.ctrl); else passes++;
        checks++; if (oa.data !== '0) $display("FAIL rst_data got %h exp 0", oa.data); else passes++;
        checks++; if (occ_a !== 2'd0) $display("FAIL rst_occ got %0d exp 0", occ_a); else passes++;
        checks++; if (ia.ready !== 1'b1) $display("FAIL rst_ready_a got %0d exp 1", ia.ready); else passes++;
        checks++; if (ib.ready !== 1'b1) $display("FAIL rst_ready_b got %0d exp 1", ib.ready); else passes++;
        reset = 0;
        step;
    endtask

    task automatic test_basic;
        logic [DW-1:0] d0;
        d0 = rnd();
        ia.valid = 1; ia.ctrl = 6'h15; ia.data = d0; oa.ready = 1;
        step;
        ia.valid = 0;
        @(negedge clk);
        checks++; if (oa.valid !== 1'b1) $display("FAIL basic_valid got %0d exp 1", oa.valid); else passes++;
        checks++; if (oa.ctrl !== 6'h15) $display("FAIL basic_ctrl got %h exp 15", oa.ctrl); else passes++;
        checks++; if (oa.data !== d0) $display("FAIL basic_data got %h exp %h", oa.data, d0); else passes++;
        checks++; if (occ_a !== 2'd1) $display("FAIL basic_occ got %0d exp 1", occ_a); else passes++;
        step;
    endtask

    task automatic test_skid;
        logic [DW-1:0] d1, d2;
        d1 = rnd(); d2 = rnd();
        oa.ready = 0; ia.valid = 1; ia.ctrl = 6'h01; ia.data = d1;
        step;
        ia.ctrl = 6'h02; ia.data = d2;
        step;
        ia.valid = 0;
        @(negedge clk);
        checks++; if (occ_a !== 2'd2) $display("FAIL skid_occ got %0d exp 2", occ_a); else passes++;
        checks++; if (ia.ready !== 1'b0) $display("FAIL skid_full_ready got %0d exp 0", ia.ready); else passes++;
        step;
        oa.ready = 1;
        @(negedge clk);
        checks++; if (oa.data !== d1 || oa.ctrl !== 6'h01) $display("FAIL skid_first got %h exp %h", oa.data, d1); else passes++;
        step;
        @(negedge clk);
        checks++; if (oa.data !== d2 || oa.ctrl !== 6'h02) $display("FAIL skid_second got %h exp %h", oa.data, d2); else passes++;
        checks++; if (ia.ready !== 1'b1) $display("FAIL skid_ready_back got %0d exp 1", ia.ready); else passes++;
        step;
        @(negedge clk);
        checks++; if (occ_a !== 2'd0) $display("FAIL skid_drained got %0d exp 0", occ_a); else passes++;
    endtask

    task automatic test_noskid;
        logic [DW-1:0] e0, e1;
        e0 = rnd(); e1 = rnd();
        ob.ready = 0; ib.valid = 1; ib.ctrl = 6'h2a; ib.data = e0;
        step;
        ib.ctrl = 6'h3f; ib.data = e1;
        @(negedge clk);
        checks++; if (ib.ready !== 1'b0) $display("FAIL noskid_stall_ready got %0d exp 0", ib.ready); else passes++;
        step;
        ob.ready = 1;
        #1;
        checks++; if (ib.ready !== 1'b1) $display("FAIL noskid_comb_ready got %0d exp 1", ib.ready); else passes++;
        step;
        ib.valid = 0;
        @(negedge clk);
        checks++; if (ob.valid !== 1'b1 || ob.ctrl !== 6'h3f) $display("FAIL noskid_replace_ctrl got %h exp 3f", ob.ctrl); else passes++;
        checks++; if (ob.data !== e1) $display("FAIL noskid_replace_data got %h exp %h", ob.data, e1); else passes++;
        step;
        @(negedge clk);
        checks++; if (occ_b !== 2'd0) $display("FAIL noskid_drained got %0d exp 0", occ_b); else passes++;
    endtask

    task automatic test_flush;
        oa.ready = 0; ia.valid = 1; ia.ctrl = 6'h07; ia.data = rnd();
        step;
        ia.ctrl = 6'h08; ia.data = rnd();
        step;
        ia.ctrl = 6'h09; ia.data = rnd(); flush_a = 1;
        step;
        flush_a = 0; ia.valid = 0; oa.ready = 1;
        @(negedge clk);
        checks++; if (oa.valid !== 1'b0) $display("FAIL flush_valid got %0d exp 0", oa.valid); else passes++;
        checks++; if (oa.ctrl !== '0) $display("FAIL flush_ctrl got %h exp 0", oa.ctrl); else passes++;
        checks++; if (occ_a !== 2'd0) $display("FAIL flush_occ got %0d exp 0", occ_a); else passes++;
        repeat (3) step;
        checks++; if (oa.valid !== 1'b0) $display("FAIL flush_ghost got %0d exp 0", oa.valid); else passes++;
        ob.ready = 0; ib.valid = 1; ib.ctrl = 6'h0a; ib.data = rnd();
        step;
        ib.ctrl = 6'h0b; ib.data = rnd(); ob.ready = 1; flush_b = 1;
        step;
        flush_b = 0; ib.valid = 0;
        @(negedge clk);
        checks++; if (ob.valid !== 1'b0 || occ_b !== 2'd0) $display("FAIL flush_b_occ got %0d exp 0", occ_b); else passes++;
        step;
    endtask

    task automatic test_async_reset;
        oa.ready = 0; ia.valid = 1; ia.ctrl = 6'h11; ia.data = rnd();
        step;
        ia.ctrl = 6'h12; ia.data = rnd();
        step;
        ia.valid = 0;
        @(negedge clk);
        checks++; if (occ_a !== 2'd2) $display("FAIL arst_pre_occ got %0d exp 2", occ_a); else passes++;
        @(posedge clk);
        #2 reset = 1;
        #1;
        checks++; if (oa.valid !== 1'b0 || oa.ctrl !== '0) $display("FAIL arst_out got %0d/%h exp 0/0", oa.valid, oa.ctrl); else passes++;
        checks++; if (oa.data !== '0) $display("FAIL arst_data got %h exp 0", oa.data); else passes++;
        checks++; if (occ_a !== 2'd0) $display("FAIL arst_occ got %0d exp 0", occ_a); else passes++;
        step;
        reset = 0; oa.ready = 1;
        @(negedge clk);
        checks++; if (ia.ready !== 1'b1) $display("FAIL arst_ready got %0d exp 1", ia.ready); else passes++;
        step;
    endtask

`ifdef EXMEM_STAGE_PERF_EN
    task automatic test_perf;
        oa.ready = 0; ia.valid = 1; ia.ctrl = 6'h05; ia.data = rnd();
        step;
        ia.valid = 0;
        repeat (10) step;
        checks++; if (stall_a !== 32'd10) $display("FAIL perf_stall got %0d exp 10", stall_a); else passes++;
        flush_a = 1;
        step;
        flush_a = 0;
        checks++; if (fcnt_a !== 32'd1) $display("FAIL perf_flush got %0d exp 1", fcnt_a); else passes++;
        flush_a = 1;
        step;
        flush_a = 0;
        checks++; if (fcnt_a !== 32'd1) $display("FAIL perf_flush_empty got %0d exp 1", fcnt_a); else passes++;
        oa.ready = 1;
        step;
    endtask
`endif

    task automatic test_back_to_back;
        int n;
        for (int i = 0; i < 300; i++) begin
            ia.valid = 1'($urandom_range(0, 1)); ia.ctrl = 6'($urandom); ia.data = rnd();
            ib.valid = 1'($urandom_range(0, 1)); ib.ctrl = 6'($urandom); ib.data = rnd();
            oa.ready = ($urandom_range(0, 3) != 0);
            ob.ready = ($urandom_range(0, 3) != 0);
            flush_a = ($urandom_range(0, 31) == 0);
            flush_b = ($urandom_range(0, 31) == 0);
            step;
        end
        ia.valid = 0; ib.valid = 0; oa.ready = 1; ob.ready = 1; flush_a = 0; flush_b = 0;
        n = 0;
        step;
        while ((qa.size() != 0 || qb.size() != 0) && n < 10) begin
            step;
            n++;
        end
        checks++;
        if (qa.size() + qb.size() != 0) $display("FAIL drain got %0d pending exp 0", qa.size() + qb.size()); else passes++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_skid();
        test_noskid();
        test_flush();
        test_async_reset();
`ifdef EXMEM_STAGE_PERF_EN
        test_perf();
`endif
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
